// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types, ASCII constants and UART report helpers.
package stopwatch_pkg;

   // Stopwatch mode encoding, shared by the counter, display decoders and report block.
   typedef enum logic [2:0] {
      IDLE    = 3'b100,
      RUNNING = 3'b001,
      CLEAR   = 3'b010
   } state_t;

   // UART report FSM.
   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_STROBE,
      S_GAP
   } rpt_state_t;

   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_I     = 8'h49;
   localparam logic [7:0] ASCII_R     = 8'h52;
   localparam logic [7:0] ASCII_C     = 8'h43;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;

   function automatic logic [7:0] mode_char(input logic [2:0] m);
      case (m)
         IDLE:    return ASCII_I;
         RUNNING: return ASCII_R;
         CLEAR:   return ASCII_C;
         default: return ASCII_QMARK;
      endcase
   endfunction

   // Byte idx of the frame "<M>:<T><U>[\r]\n".
   function automatic logic [7:0] frame_char(input logic [2:0] idx,
                                             input logic [2:0] m,
                                             input logic [3:0] tens,
                                             input logic [3:0] units,
                                             input bit         crlf);
      case (idx)
         3'd0:    return mode_char(m);
         3'd1:    return ASCII_COLON;
         3'd2:    return ASCII_ZERO + {4'h0, tens};
         3'd3:    return ASCII_ZERO + {4'h0, units};
         3'd4:    return crlf ? ASCII_CR : ASCII_LF;
         default: return ASCII_LF;
      endcase
   endfunction

endpackage

// File: rtl/stopwatch_uart_report_bin2dec2.sv
// Combinational binary (< 100) to two BCD digits.
module bin2dec2 #(
   parameter int unsigned TIME_W = 5
) (
   input  logic [TIME_W-1:0] bin,
   output logic [3:0]        tens,
   output logic [3:0]        units
);

   logic [6:0] v;

   // Constant-divisor split into tens and units.
   always_comb begin
      v     = 7'(bin);
      tens  = 4'(v / 7'd10);
      units = 4'(v % 7'd10);
   end

endmodule

// File: rtl/stopwatch_uart_report.sv
// Streams "<M>:<T><U>\r\n" to the UART whenever stopwatch mode/time changes.
module stopwatch_uart_report
   import stopwatch_pkg::*;
#(
   parameter int unsigned TIME_W   = 5,
   parameter bit          EOL_CRLF = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_i,
   input  logic [2:0]        mode_i,
   input  logic [TIME_W-1:0] time_i,
   input  logic              txready_i,
   output logic [7:0]        txdata_o,
   output logic              txclk_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [2:0] LAST_IDX = EOL_CRLF ? 3'd5 : 3'd4;

   rpt_state_t        state, state_nxt;
   logic [2:0]        snap_mode;
   logic [TIME_W-1:0] snap_time;
   logic              snap_vld;
   logic [2:0]        idx;
   logic              start;
   logic              last;
   logic [3:0]        tens, units;

   assign last = (idx == LAST_IDX);

   bin2dec2 #(.TIME_W(TIME_W)) u_bin2dec2 (
      .bin   (snap_time),
      .tens  (tens),
      .units (units)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode and strobe/status outputs.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      txclk_o   = 1'b0;
      done_o    = 1'b0;
      busy_o    = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (en_i && (!snap_vld || {mode_i, time_i} != {snap_mode, snap_time})) begin
               start     = 1'b1;
               state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (txready_i) state_nxt = S_STROBE;
         end
         S_STROBE: begin
            txclk_o   = 1'b1;
            done_o    = last;
            state_nxt = S_GAP;
         end
         S_GAP: begin
            state_nxt = last ? S_IDLE : S_SEND;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Snapshot, byte index and data register. The byte is loaded on entry to
   // S_SEND so txdata_o is already valid during the whole send/stall window;
   // byte 0 only needs the mode, which equals the value being captured.
   always_ff @(posedge clk) begin
      if (reset) begin
         txdata_o  <= '0;
         idx       <= '0;
         snap_vld  <= 1'b0;
         snap_mode <= '0;
         snap_time <= '0;
      end else if (start) begin
         snap_mode <= mode_i;
         snap_time <= time_i;
         snap_vld  <= 1'b1;
         idx       <= '0;
         txdata_o  <= mode_char(mode_i);
      end else if (state == S_GAP && !last) begin
         idx      <= idx + 3'd1;
         txdata_o <= frame_char(idx + 3'd1, snap_mode, tens, units, EOL_CRLF);
      end
   end

endmodule

// File: tb/tb_stopwatch_uart_report.sv
module tb_stopwatch_uart_report;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en_i = 1'b1;
   logic [2:0] mode_i = 3'b100;
   logic [4:0] time_i = 5'd0;
   logic       txready_i = 1'b1;
   logic [7:0] txdata_o, txdata2;
   logic       txclk_o, busy_o, done_o, txclk2, busy2, done2;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0, done2_cnt = 0, bad_done = 0;
   logic [7:0] rxq[$], rx2[$], expq[$], exp2q[$];

   always #5 clk = ~clk;

   stopwatch_uart_report dut (
      .clk(clk), .reset(reset), .en_i(en_i), .mode_i(mode_i), .time_i(time_i),
      .txready_i(txready_i), .txdata_o(txdata_o), .txclk_o(txclk_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   stopwatch_uart_report #(.TIME_W(5), .EOL_CRLF(1'b0)) dut_lf (
      .clk(clk), .reset(reset), .en_i(en_i), .mode_i(mode_i), .time_i(time_i),
      .txready_i(txready_i), .txdata_o(txdata2), .txclk_o(txclk2),
      .busy_o(busy2), .done_o(done2)
   );

   // Byte capture: a byte counts as sent on each cycle its strobe is high.
   always @(negedge clk) begin
      if (txclk_o) rxq.push_back(txdata_o);
      if (done_o) done_cnt++;
      if (done_o && !txclk_o) bad_done++;
      if (txclk2) rx2.push_back(txdata2);
      if (done2) done2_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference frame built from the textual format rules.
   task automatic push_frame(input logic [2:0] m, input int t, input bit crlf, input bit to2);
      byte c;
      byte f[$];
      case (m)
         3'b100:  c = "I";
         3'b001:  c = "R";
         3'b010:  c = "C";
         default: c = "?";
      endcase
      f.push_back(c);
      f.push_back(":");
      f.push_back(8'(48 + t / 10));
      f.push_back(8'(48 + t % 10));
      if (crlf) f.push_back(8'd13);
      f.push_back(8'd10);
      foreach (f[i]) begin
         if (to2) exp2q.push_back(f[i]);
         else     expq.push_back(f[i]);
      end
   endtask

   task automatic compare_rx(input string tag);
      check({tag, "_len"}, rxq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < rxq.size(); i++)
         check($sformatf("%s_b%0d", tag, i), rxq[i], expq[i]);
      rxq.delete();
      expq.delete();
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Wait for n more completed frames; optional random txready jitter.
   task automatic wait_frames(input int n, input bit jitter, input string tag);
      int target;
      target = done_cnt + n;
      for (int k = 0; k < 3000 && done_cnt < target; k++) begin
         @(posedge clk); #1;
         txready_i = jitter ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      txready_i = 1'b1;
      check({tag, "_done_seen"}, 32'(done_cnt >= target), 32'd1);
      cyc(2);
   endtask

   initial begin
      int n, ok, d0, d2, t;
      logic [2:0] m;

      // 1: reset, first frame always sent, then quiet
      cyc(3);
      @(negedge clk);
      check("rst_txdata", txdata_o, 8'h00);
      check("rst_txclk", txclk_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      wait_frames(1, 0, "t1");
      push_frame(3'b100, 0, 1, 0);
      compare_rx("t1");
      check("t1_done_once", done_cnt, 1);
      cyc(30);
      check("t1_quiet", rxq.size(), 0);
      check("t1_quiet_done", done_cnt, 1);
      check("t1_idle_busy", busy_o, 0);

      // 2: RUNNING frames, and LF-only build
      mode_i = 3'b001; time_i = 5'd17;
      wait_frames(1, 0, "t2a");
      push_frame(3'b001, 17, 1, 0);
      compare_rx("t2a");
      rx2.delete();
      d2 = done2_cnt;
      time_i = 5'd31;
      wait_frames(1, 0, "t2b");
      push_frame(3'b001, 31, 1, 0);
      compare_rx("t2b");
      push_frame(3'b001, 31, 0, 1);
      check("t2lf_done", done2_cnt, d2 + 1);
      check("t2lf_len", rx2.size(), exp2q.size());
      for (int i = 0; i < exp2q.size() && i < rx2.size(); i++)
         check($sformatf("t2lf_b%0d", i), rx2[i], exp2q[i]);
      exp2q.delete();

      // 3: stall on byte 2 (tens '1')
      time_i = 5'd12;
      ok = 0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (txclk_o && txdata_o == 8'h3A) ok = 1;
      end
      check("t3_colon_seen", ok, 1);
      txready_i = 1'b0;
      @(negedge clk);
      check("t3_gap_txclk", txclk_o, 0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("t3_stall_txclk", txclk_o, 0);
         check("t3_stall_data", txdata_o, 8'h31);
      end
      check("t3_stall_busy", busy_o, 1);
      @(posedge clk); #1;
      wait_frames(1, 0, "t3");
      push_frame(3'b001, 12, 1, 0);
      compare_rx("t3");

      // 4: coalescing, only latest value follows
      d0 = done_cnt;
      time_i = 5'd4;
      ok = 0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (txclk_o) ok = 1;
      end
      check("t4_first_strobe", ok, 1);
      @(posedge clk); #1; time_i = 5'd5;
      cyc(3);             time_i = 5'd6;
      cyc(3);             time_i = 5'd7;
      for (int k = 0; k < 300 && done_cnt < d0 + 2; k++) cyc(1);
      cyc(30);
      check("t4_frames", done_cnt, d0 + 2);
      push_frame(3'b001, 4, 1, 0);
      push_frame(3'b001, 7, 1, 0);
      compare_rx("t4");

      // 5: reset during strobe of byte 3 abandons the frame
      time_i = 5'd9;
      n = 0;
      for (int k = 0; k < 200 && n < 4; k++) begin
         @(negedge clk);
         if (txclk_o) n++;
      end
      check("t5_reached_b3", n, 4);
      d0 = done_cnt;
      reset = 1'b1;
      @(negedge clk);
      check("t5_txclk", txclk_o, 0);
      check("t5_busy", busy_o, 0);
      check("t5_done", done_o, 0);
      check("t5_no_done", done_cnt, d0);
      @(posedge clk); #1;
      reset = 1'b0;
      rxq.delete();
      rx2.delete();
      wait_frames(1, 0, "t5");
      push_frame(3'b001, 9, 1, 0);
      compare_rx("t5");

      // 6: unknown mode, then en_i gating
      mode_i = 3'b111; time_i = 5'($urandom_range(0, 31));
      t = int'(time_i);
      wait_frames(1, 0, "t6a");
      check("t6_qmark", rxq.size() > 0 ? rxq[0] : 8'h00, 8'h3F);
      push_frame(3'b111, t, 1, 0);
      compare_rx("t6a");
      en_i = 1'b0;
      mode_i = 3'b100; time_i = 5'd3;
      cyc(10);
      mode_i = 3'b010; time_i = 5'd22;
      cyc(30);
      check("t6_gated", rxq.size(), 0);
      check("t6_gated_busy", busy_o, 0);
      en_i = 1'b1;
      wait_frames(1, 0, "t6b");
      push_frame(3'b010, 22, 1, 0);
      compare_rx("t6b");

      // Randomized frames with random ready stalls
      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 3))
            0:       m = 3'b100;
            1:       m = 3'b001;
            2:       m = 3'b010;
            default: m = 3'($urandom_range(0, 7));
         endcase
         t = int'($urandom_range(0, 31));
         if ({m, 5'(t)} == {mode_i, time_i}) t = (t + 1) % 32;
         mode_i = m; time_i = 5'(t);
         wait_frames(1, 1, "rnd");
         push_frame(m, t, 1, 0);
         compare_rx($sformatf("rnd%0d", it));
         rx2.delete();
      end

      check("done_with_strobe", bad_done, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
